// File: rtl/johnson_ring_decoder.sv
// rtl/johnson_ring_decoder.sv - ring/Johnson state decoder with sequence check, lock FSM and error count
// Optional JRD_DIR_DETECT_EN: adds dir output and accepts downward steps.
module johnson_ring_decoder #(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             mode,
    input  logic [4:0]       din,
    input  logic             din_vld,
    output logic [3:0]       idx,
    output logic             idx_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
`ifdef JRD_DIR_DETECT_EN
    ,
    output logic             dir
`endif
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [3:0] LOCK_Q = 4'(LOCK_CNT);

    state_t           state_q;
    logic [3:0]       idx_q;
    logic             idx_vld_q;
    logic             illegal_q;
    logic             seq_err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [3:0]       prev_q;
    logic             prev_vld_q;
    logic             mode_q;
    logic [3:0]       good_q;

    logic             code_ok;
    logic [3:0]       code_idx;
    logic [3:0]       last_idx;
    logic [3:0]       succ_idx;
    logic [3:0]       good_d;
    logic             step_ok;

    always_comb begin
        code_ok  = 1'b1;
        code_idx = 4'd0;
        if (!mode) begin
            case (din)
                5'b00001: code_idx = 4'd0;
                5'b00010: code_idx = 4'd1;
                5'b00100: code_idx = 4'd2;
                5'b01000: code_idx = 4'd3;
                5'b10000: code_idx = 4'd4;
                default:  code_ok  = 1'b0;
            endcase
        end else begin
            case (din)
                5'b00000: code_idx = 4'd0;
                5'b00001: code_idx = 4'd1;
                5'b00011: code_idx = 4'd2;
                5'b00111: code_idx = 4'd3;
                5'b01111: code_idx = 4'd4;
                5'b11111: code_idx = 4'd5;
                5'b11110: code_idx = 4'd6;
                5'b11100: code_idx = 4'd7;
                5'b11000: code_idx = 4'd8;
                5'b10000: code_idx = 4'd9;
                default:  code_ok  = 1'b0;
            endcase
        end
    end

    assign last_idx = mode ? 4'd9 : 4'd4;
    assign succ_idx = (prev_q == last_idx) ? 4'd0 : prev_q + 4'd1;
    assign good_d   = (good_q >= LOCK_Q) ? good_q : good_q + 4'd1;

`ifdef JRD_DIR_DETECT_EN
    logic [3:0] pred_idx;
    logic       dir_q;
    logic       dir_d;
    logic       dir_free;

    assign pred_idx = (prev_q == 4'd0) ? last_idx : prev_q - 4'd1;
    // Direction is only open until the first correct step of a hunt.
    assign dir_free = (state_q == HUNT) && (good_q == 4'd0);

    always_comb begin
        dir_d   = dir_q;
        step_ok = 1'b0;
        if (dir_free) begin
            step_ok = (code_idx == succ_idx) || (code_idx == pred_idx);
            dir_d   = (code_idx != succ_idx);
        end else begin
            step_ok = dir_q ? (code_idx == pred_idx) : (code_idx == succ_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            dir_q <= 1'b0;
        end else if (din_vld && code_ok && prev_vld_q && (mode == mode_q) && step_ok) begin
            dir_q <= dir_d;
        end
    end

    assign dir = dir_q;
`else
    assign step_ok = (code_idx == succ_idx);
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= HUNT;
            idx_q      <= 4'd0;
            idx_vld_q  <= 1'b0;
            illegal_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            err_cnt_q  <= '0;
            prev_q     <= 4'd0;
            prev_vld_q <= 1'b0;
            mode_q     <= 1'b0;
            good_q     <= 4'd0;
        end else if (din_vld) begin
            mode_q    <= mode;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            if (!code_ok) begin
                illegal_q  <= 1'b1;
                idx_vld_q  <= 1'b0;
                prev_vld_q <= 1'b0;
                good_q     <= 4'd0;
                state_q    <= HUNT;
                if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + ERR_W'(1);
            end else begin
                idx_q      <= code_idx;
                idx_vld_q  <= 1'b1;
                prev_q     <= code_idx;
                prev_vld_q <= 1'b1;
                // A mode switch restarts the hunt without blaming the sender.
                if (!prev_vld_q || (mode != mode_q)) begin
                    good_q  <= 4'd0;
                    state_q <= HUNT;
                end else if (step_ok) begin
                    good_q <= good_d;
                    if (good_d == LOCK_Q) state_q <= LOCKED;
                end else begin
                    seq_err_q <= 1'b1;
                    good_q    <= 4'd0;
                    state_q   <= HUNT;
                    if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
            end
        end else begin
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = idx_vld_q;
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;
    assign locked  = (state_q == LOCKED);
    assign err_cnt = err_cnt_q;

endmodule
